// File: rtl/interboard_receiver.sv
// rtl/interboard_receiver.sv - two-beat 4-phase handshake receiver for peer board messages
module interboard_receiver #(
    parameter int       SYNC_STAGES    = 2,
    parameter int       TIMEOUT_CYCLES = 1_000_000,
    parameter logic [2:0] RST_TYPE     = 3'b111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Request_in,
    input  logic [5:0] inter_data_in,
    output logic       Ack_out,
    output logic       interboard_en,
    output logic [2:0] interboard_msg_type,
    output logic [4:0] interboard_number,
    output logic       interboard_rst,
    output logic       busy,
    output logic       frame_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ACK0, WAIT1, ACK1, EMIT} state_t;

    state_t                 state, next_state;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   req_s;
    logic [CW-1:0]          tcnt;
    logic [2:0]             type_r, type_d;
    logic [4:0]             num_r, num_d;
    logic                   bad_r, bad_d;
    logic                   need_low, low_d;
    logic                   ack_d, err_d, en_d, rst_d, timeout;
    logic [2:0]             mt_d;
    logic [4:0]             nb_d;

    assign req_s = sync_r[SYNC_STAGES-1];
    assign busy  = (state != IDLE);

    always_comb begin
        next_state = state;
        ack_d      = Ack_out;
        type_d     = type_r;
        num_d      = num_r;
        bad_d      = bad_r;
        err_d      = frame_err;
        low_d      = need_low;
        en_d       = 1'b0;
        rst_d      = 1'b0;
        mt_d       = interboard_msg_type;
        nb_d       = interboard_number;
        timeout    = (state == ACK0 || state == WAIT1 || state == ACK1) && (tcnt == T_LAST);
        if (!req_s) low_d = 1'b0;
        case (state)
            IDLE: begin
                // A request that outlived a timeout must drop before it can start a new message
                if (req_s && !need_low) begin
                    type_d     = inter_data_in[5:3];
                    bad_d      = (inter_data_in[2:0] != 3'b000);
                    err_d      = frame_err | bad_d;
                    ack_d      = 1'b1;
                    next_state = ACK0;
                end
            end
            ACK0: begin
                if (!req_s) begin
                    ack_d      = 1'b0;
                    next_state = bad_r ? IDLE : WAIT1;
                end
            end
            WAIT1: begin
                if (req_s) begin
                    num_d      = inter_data_in[4:0];
                    bad_d      = inter_data_in[5];
                    err_d      = frame_err | bad_d;
                    ack_d      = 1'b1;
                    next_state = ACK1;
                end
            end
            ACK1: begin
                if (!req_s) begin
                    ack_d      = 1'b0;
                    next_state = bad_r ? IDLE : EMIT;
                end
            end
            EMIT: begin
                en_d       = 1'b1;
                rst_d      = (type_r == RST_TYPE);
                mt_d       = type_r;
                nb_d       = num_r;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // A beat completing on the same edge wins over the timeout
        if (timeout && next_state == state) begin
            next_state = IDLE;
            ack_d      = 1'b0;
            err_d      = 1'b1;
            low_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            sync_r              <= '0;
            tcnt                <= '0;
            type_r              <= '0;
            num_r               <= '0;
            bad_r               <= 1'b0;
            need_low            <= 1'b0;
            Ack_out             <= 1'b0;
            frame_err           <= 1'b0;
            interboard_en       <= 1'b0;
            interboard_rst      <= 1'b0;
            interboard_msg_type <= '0;
            interboard_number   <= '0;
        end else begin
            state               <= next_state;
            sync_r              <= {sync_r[SYNC_STAGES-2:0], Request_in};
            if (next_state != state || state == IDLE || state == EMIT)
                tcnt <= '0;
            else
                tcnt <= tcnt + 1'b1;
            type_r              <= type_d;
            num_r               <= num_d;
            bad_r               <= bad_d;
            need_low            <= low_d;
            Ack_out             <= ack_d;
            frame_err           <= err_d;
            interboard_en       <= en_d;
            interboard_rst      <= rst_d;
            interboard_msg_type <= mt_d;
            interboard_number   <= nb_d;
        end
    end

endmodule

// File: tb/tb_interboard_receiver.sv
// tb/tb_interboard_receiver.sv - scoreboard bench for interboard_receiver
module tb_interboard_receiver;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       Request_in;
    logic [5:0] inter_data_in;
    logic       Ack_out;
    logic       interboard_en;
    logic [2:0] interboard_msg_type;
    logic [4:0] interboard_number;
    logic       interboard_rst;
    logic       busy;
    logic       frame_err;

    always #5 clk = ~clk;

    interboard_receiver #(
        .SYNC_STAGES(2),
        .TIMEOUT_CYCLES(TO),
        .RST_TYPE(3'b111)
    ) dut (
        .clk(clk),
        .rst(rst),
        .Request_in(Request_in),
        .inter_data_in(inter_data_in),
        .Ack_out(Ack_out),
        .interboard_en(interboard_en),
        .interboard_msg_type(interboard_msg_type),
        .interboard_number(interboard_number),
        .interboard_rst(interboard_rst),
        .busy(busy),
        .frame_err(frame_err)
    );

    typedef struct packed {
        logic [2:0] t;
        logic [4:0] n;
        logic       r;
    } msg_t;

    int   checks   = 0;
    int   failures = 0;
    msg_t exp_q[$];
    msg_t obs_mem[64];
    int   obs_wr    = 0;
    int   obs_rd    = 0;
    int   stray_rst = 0;

    always @(negedge clk) begin
        if (interboard_en === 1'b1 && obs_wr < 64) begin
            obs_mem[obs_wr] <= {interboard_msg_type, interboard_number, interboard_rst};
            obs_wr <= obs_wr + 1;
        end
        if (interboard_rst === 1'b1 && interboard_en !== 1'b1)
            stray_rst <= stray_rst + 1;
    end

    task automatic wait_ack(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            if (Ack_out === lvl) ok = 1'b1;
        end
    endtask

    task automatic send_beat(input logic [5:0] d, output bit ok);
        bit ok1, ok2;
        inter_data_in = d;
        Request_in    = 1'b1;
        wait_ack(1'b1, ok1);
        Request_in    = 1'b0;
        wait_ack(1'b0, ok2);
        ok = ok1 & ok2;
    endtask

    task automatic send_msg(input logic [2:0] t, input logic [4:0] n);
        bit ok0, ok1;
        msg_t m;
        m.t = t;
        m.n = n;
        m.r = (t == 3'b111);
        exp_q.push_back(m);
        send_beat({t, 3'b000}, ok0);
        send_beat({1'b0, n}, ok1);
        checks++;
        if (!(ok0 && ok1)) begin
            failures++;
            $display("FAIL send_msg_handshake: ok=%0d required 1", ok0 && ok1);
        end
    endtask

    task automatic check_sb(input string name);
        msg_t e, o;
        repeat (6) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin
                failures++;
                $display("FAIL %s_missing: no interboard_en, required t=%0d n=%0d r=%0d", name, e.t, e.n, e.r);
            end else begin
                o = obs_mem[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL %s_msg: got t=%0d n=%0d r=%0d required t=%0d n=%0d r=%0d",
                             name, o.t, o.n, o.r, e.t, e.n, e.r);
                end
            end
        end
        checks++;
        if (obs_wr !== obs_rd) begin
            failures++;
            $display("FAIL %s_extra: got %0d extra pulses required 0", name, obs_wr - obs_rd);
            obs_rd = obs_wr;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        Request_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        obs_rd = obs_wr;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        Request_in    = 1'b0;
        inter_data_in = 6'd0;
        @(posedge clk); #1;
        checks++;
        if ({Ack_out, interboard_en, interboard_rst, busy, frame_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 00000",
                     {Ack_out, interboard_en, interboard_rst, busy, frame_err});
        end
        checks++;
        if ({interboard_msg_type, interboard_number} !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs: got t=%0d n=%0d required 0 0", interboard_msg_type, interboard_number);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        bit ok0, ok1;
        msg_t m;
        m.t = 3'b010; m.n = 5'd22; m.r = 1'b0;
        exp_q.push_back(m);
        send_beat(6'b010_000, ok0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL nominal_busy: got %0d required 1", busy);
        end
        send_beat(6'b0_10110, ok1);
        @(posedge clk); #1;
        checks++;
        if ({interboard_en, interboard_rst, interboard_msg_type, interboard_number} !== {1'b1, 1'b0, 3'b010, 5'd22}) begin
            failures++;
            $display("FAIL nominal_latency: got en=%0d rst=%0d t=%0d n=%0d required en=1 rst=0 t=2 n=22",
                     interboard_en, interboard_rst, interboard_msg_type, interboard_number);
        end
        @(posedge clk); #1;
        checks++;
        if (interboard_en !== 1'b0 || frame_err !== 1'b0 || !(ok0 && ok1)) begin
            failures++;
            $display("FAIL nominal_pulse: got en=%0d frame_err=%0d ok=%0d required 0 0 1",
                     interboard_en, frame_err, ok0 && ok1);
        end
        check_sb("nominal");
    endtask

    task automatic test_rst_msg();
        bit ok0, ok1;
        msg_t m;
        m.t = 3'b111; m.n = 5'd5; m.r = 1'b1;
        exp_q.push_back(m);
        send_beat(6'b111_000, ok0);
        send_beat(6'b0_00101, ok1);
        @(posedge clk); #1;
        checks++;
        if ({interboard_en, interboard_rst} !== 2'b11) begin
            failures++;
            $display("FAIL rstmsg_pulse: got en=%0d rst=%0d required 1 1", interboard_en, interboard_rst);
        end
        @(posedge clk); #1;
        checks++;
        if ({interboard_en, interboard_rst} !== 2'b00) begin
            failures++;
            $display("FAIL rstmsg_single: got en=%0d rst=%0d required 0 0", interboard_en, interboard_rst);
        end
        check_sb("rstmsg");
    endtask

    task automatic test_framing();
        bit ok0, ok1;
        send_beat(6'b001_101, ok0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (!ok0 || frame_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL framing_beat0: got ok=%0d frame_err=%0d busy=%0d required 1 1 0", ok0, frame_err, busy);
        end
        checks++;
        if (interboard_msg_type !== 3'b111 || interboard_number !== 5'd5) begin
            failures++;
            $display("FAIL framing_hold: got t=%0d n=%0d required 7 5", interboard_msg_type, interboard_number);
        end
        check_sb("framing0");
        do_reset();
        send_beat(6'b100_000, ok0);
        send_beat(6'b1_00011, ok1);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (!(ok0 && ok1) || frame_err !== 1'b1) begin
            failures++;
            $display("FAIL framing_beat1: got ok=%0d frame_err=%0d required 1 1", ok0 && ok1, frame_err);
        end
        check_sb("framing1");
    endtask

    task automatic test_timeout();
        bit ok, stuck_ok;
        int n;
        do_reset();
        inter_data_in = 6'b011_000;
        Request_in    = 1'b1;
        wait_ack(1'b1, ok);
        n = 0;
        for (int i = 1; i <= 100 && n == 0; i++) begin
            @(posedge clk); #1;
            if (Ack_out === 1'b0) n = i;
        end
        checks++;
        if (!ok || n != TO) begin
            failures++;
            $display("FAIL timeout_cycles: got %0d required %0d", n, TO);
        end
        checks++;
        if (frame_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_flags: got frame_err=%0d busy=%0d required 1 0", frame_err, busy);
        end
        stuck_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (Ack_out !== 1'b0 || busy !== 1'b0) stuck_ok = 1'b0;
        end
        checks++;
        if (!stuck_ok) begin
            failures++;
            $display("FAIL timeout_no_reentry: got reentry=1 required 0");
        end
        Request_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        send_msg(3'b011, 5'd9);
        check_sb("timeout");
    endtask

    task automatic test_reset_mid();
        bit ok, ok1;
        send_beat(6'b101_000, ok);
        inter_data_in = 6'b0_01111;
        Request_in    = 1'b1;
        wait_ack(1'b1, ok1);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({Ack_out, busy, interboard_en, interboard_rst, frame_err, interboard_msg_type, interboard_number} !== 13'd0
            || !(ok && ok1)) begin
            failures++;
            $display("FAIL resetmid_outputs: got ack=%0d busy=%0d en=%0d rst=%0d ferr=%0d t=%0d n=%0d required all 0",
                     Ack_out, busy, interboard_en, interboard_rst, frame_err, interboard_msg_type, interboard_number);
        end
        rst        = 1'b0;
        Request_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_sb("resetmid_idle");
        send_msg(3'b101, 5'd15);
        check_sb("resetmid_next");
    endtask

    task automatic test_back_to_back();
        send_msg(3'b001, 5'd1);
        send_msg(3'b110, 5'd30);
        send_msg(3'b111, 5'd31);
        check_sb("b2b");
        checks++;
        if (stray_rst != 0) begin
            failures++;
            $display("FAIL stray_interboard_rst: got %0d required 0", stray_rst);
        end
    endtask

    initial begin
        rst           = 1'b1;
        Request_in    = 1'b0;
        inter_data_in = 6'd0;
        test_reset();
        test_nominal();
        test_rst_msg();
        test_framing();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
